// File: rtl/boot_loader_pkg.sv
// Shared constants and FSM state type for the boot ROM copy sequencer.
package boot_loader_pkg;

    localparam int unsigned BOOT_ROM_DEPTH = 512;
    localparam int unsigned BOOT_ROM_AW    = 9;
    localparam int unsigned BOOT_DST_W     = 16;
    localparam logic [15:0] BOOT_DST_BASE  = 16'h0200;

    typedef enum logic [2:0] {
        FETCH    = 3'd0,
        WRITE    = 3'd1,
        DONE     = 3'd2,
        HOST_RD  = 3'd3,
        HOST_ACK = 3'd4
    } boot_state_e;

endpackage

// File: rtl/boot_checksum.sv
// 8-bit mod-256 accumulator with synchronous clear and add-enable.
module boot_checksum (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic       add_en_i,
    input  logic [7:0] data_i,
    output logic [7:0] sum_o
);

    logic [7:0] sum_q;
    logic [7:0] sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clear_i) begin
            sum_d = 8'h00;
        end else if (add_en_i) begin
            sum_d = sum_q + data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sum_q <= 8'h00;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/boot_loader_ctrl.sv
// Copies the boot ROM into main memory after reset, then serves host byte reads.
// Optional image checksum enabled by defining BOOT_LOADER_CHECKSUM_EN.
module boot_loader_ctrl
    import boot_loader_pkg::*;
#(
    parameter int unsigned       ROM_DEPTH = BOOT_ROM_DEPTH,
    parameter int unsigned       ADDR_W    = BOOT_ROM_AW,
    parameter int unsigned       DST_W     = BOOT_DST_W,
    parameter logic [DST_W-1:0]  DST_BASE  = DST_W'(BOOT_DST_BASE)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              restart_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [7:0]        rom_rddata_i,
    output logic              mem_wr_valid_o,
    input  logic              mem_wr_ready_i,
    output logic [DST_W-1:0]  mem_wr_addr_o,
    output logic [7:0]        mem_wr_data_o,
    output logic              cpu_hold_o,
    input  logic              host_rd_req_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    output logic              host_rd_ack_o,
    output logic [7:0]        host_rddata_o,
    output logic [7:0]        checksum_o,
    output logic              checksum_ok_o
);

    boot_state_e       state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] haddr_q, haddr_d;
    logic [7:0]        host_rddata_q, host_rddata_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= FETCH;
            idx_q         <= '0;
            haddr_q       <= '0;
            host_rddata_q <= 8'h00;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            haddr_q       <= haddr_d;
            host_rddata_q <= host_rddata_d;
        end
    end

    // The ROM address is held through WRITE so a stalled write keeps seeing the same byte.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        haddr_d        = haddr_q;
        host_rddata_d  = host_rddata_q;
        rom_addr_o     = idx_q;
        mem_wr_valid_o = 1'b0;
        mem_wr_data_o  = 8'h00;
        cpu_hold_o     = 1'b0;
        host_rd_ack_o  = 1'b0;

        case (state_q)
            FETCH: begin
                cpu_hold_o = 1'b1;
                state_d    = WRITE;
            end
            WRITE: begin
                cpu_hold_o     = 1'b1;
                mem_wr_valid_o = 1'b1;
                mem_wr_data_o  = rom_rddata_i;
                if (mem_wr_ready_i) begin
                    if (idx_q == ADDR_W'(ROM_DEPTH - 1)) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                rom_addr_o = host_addr_i;
                if (restart_i) begin
                    idx_d   = '0;
                    state_d = FETCH;
                end else if (host_rd_req_i) begin
                    haddr_d = host_addr_i;
                    state_d = HOST_RD;
                end
            end
            HOST_RD: begin
                rom_addr_o    = haddr_q;
                host_rddata_d = rom_rddata_i;
                state_d       = HOST_ACK;
            end
            HOST_ACK: begin
                rom_addr_o    = haddr_q;
                host_rd_ack_o = 1'b1;
                state_d       = DONE;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign mem_wr_addr_o = DST_BASE + DST_W'(idx_q);
    assign host_rddata_o = host_rddata_q;

`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [7:0] sum;

    boot_checksum u_checksum (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  ((state_q == DONE) && restart_i),
        .add_en_i ((state_q == WRITE) && mem_wr_ready_i),
        .data_i   (rom_rddata_i),
        .sum_o    (sum)
    );

    assign checksum_o    = sum;
    assign checksum_ok_o = (state_q == DONE) && (sum == 8'h00);
`else
    assign checksum_o    = 8'h00;
    assign checksum_ok_o = 1'b1;
`endif

endmodule
